// File: rtl/tagger_readout_arbiter_pkg.sv
// Shared definitions for the tagger readout arbiter: FSM encoding,
// acknowledge timeout and record geometry defaults.
package tagger_readout_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_ACK      = 2'd2,
    ST_WAIT_CLR = 2'd3
  } state_t;

  localparam int WAIT_CLR_TIMEOUT = 16;
  localparam int TMO_W            = $clog2(WAIT_CLR_TIMEOUT);
  localparam int DEFAULT_N_WORDS  = 6;

  // LSB position of word w of block b inside the flattened event bus
  function automatic int word_lsb(input int blk, input int word, input int n_words);
    return (blk * n_words + word) * 32;
  endfunction

endpackage

// File: rtl/tagger_readout_arbiter_rr_grant.sv
// Round-robin grant search: first request found scanning upward from
// i_ptr+1 with wrap-around. Purely combinational.
module rr_grant #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_req,
  input  logic [2:0]   i_ptr,
  output logic [N-1:0] o_grant,
  output logic [2:0]   o_idx
);

  localparam int IW = $clog2(N);

  logic          w_found;
  logic [IW-1:0] w_cand;

  // Scan N candidates starting one past the last grant; keep the first hit
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= N; k++) begin
      w_cand = IW'((int'(i_ptr) + k) % N);
      if (!w_found && i_req[w_cand]) begin
        w_found          = 1'b1;
        o_grant[w_cand]  = 1'b1;
        o_idx            = 3'(w_cand);
      end
    end
  end

endmodule

// File: rtl/tagger_readout_arbiter.sv
// Arbitrates event readout from N_BLK tagger blocks onto a single
// valid/ready word stream towards the HPS bridge, then handshakes the
// notify/ack pair with the served block.
//
// state    | meaning
// ---------|-----------------------------------------------------------
// IDLE     | waiting for any notify; grants round-robin, loads word 0
// SEND     | streaming words of the granted block, one per rd_ready
// ACK      | record done; ack raised, event counter bumped
// WAIT_CLR | holding ack until the block drops notify or timeout expires
module tagger_readout_arbiter
  import tagger_readout_arbiter_pkg::*;
#(
  parameter int N_BLK   = 4,
  parameter int N_WORDS = DEFAULT_N_WORDS
) (
  input  logic                       clk_5,
  input  logic                       rst,
  input  logic [N_BLK-1:0]           notify_evt,
  input  logic [N_BLK*N_WORDS*32-1:0] blk_data,
  output logic [N_BLK-1:0]           ack_evt,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [31:0]                rd_data,
  output logic [2:0]                 rd_src,
  output logic                       rd_last,
  output logic [31:0]                evt_count,
  output logic                       ack_timeout
);

  localparam int                WIDX_W  = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [WIDX_W-1:0] LAST_W  = WIDX_W'(N_WORDS - 1);
  localparam logic [2:0]        PTR_RST = 3'(N_BLK - 1);

  state_t              r_state, w_state_nxt;
  logic [2:0]          r_src, r_last_grant;
  logic [WIDX_W-1:0]   r_widx;
  logic                r_rd_valid, r_rd_last, r_ack_timeout;
  logic [31:0]         r_rd_data, r_evt_count;
  logic [TMO_W-1:0]    r_tmo_cnt;

  logic [N_BLK-1:0]    w_grant, w_ack_evt;
  logic [2:0]          w_grant_idx, w_ld_blk;
  logic [WIDX_W-1:0]   w_ld_word;
  logic [31:0]         w_ld_data;
  logic                w_grant_any, w_xfer, w_xfer_last, w_src_notify;

  rr_grant #(.N(N_BLK)) u_rr_grant (
    .i_req   (notify_evt),
    .i_ptr   (r_last_grant),
    .o_grant (w_grant),
    .o_idx   (w_grant_idx)
  );

  assign w_grant_any = |w_grant;
  assign w_xfer      = r_rd_valid & rd_ready;
  assign w_xfer_last = w_xfer & (r_widx == LAST_W);

  // Word to load into the output register: word 0 of the new grant in IDLE,
  // otherwise the word following the one currently presented
  assign w_ld_blk  = (r_state == ST_IDLE) ? w_grant_idx : r_src;
  assign w_ld_word = (r_state == ST_IDLE) ? '0 : r_widx + 1'b1;

  // Select the load word and the served block's notify from the wide buses
  always_comb begin
    w_ld_data    = '0;
    w_src_notify = 1'b0;
    for (int b = 0; b < N_BLK; b++) begin
      if (r_src == 3'(b)) w_src_notify = notify_evt[b];
      for (int w = 0; w < N_WORDS; w++) begin
        if (w_ld_blk == 3'(b) && w_ld_word == WIDX_W'(w))
          w_ld_data = blk_data[word_lsb(b, w, N_WORDS) +: 32];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk_5 or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and acknowledge decode
  always_comb begin
    w_state_nxt = r_state;
    w_ack_evt   = '0;
    case (r_state)
      ST_IDLE:     if (w_grant_any) w_state_nxt = ST_SEND;
      ST_SEND:     if (w_xfer_last) w_state_nxt = ST_ACK;
      ST_ACK:      w_state_nxt = ST_WAIT_CLR;
      ST_WAIT_CLR: if (!w_src_notify || r_tmo_cnt == '0) w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
    if (r_state == ST_ACK || r_state == ST_WAIT_CLR) begin
      for (int b = 0; b < N_BLK; b++)
        if (r_src == 3'(b)) w_ack_evt[b] = 1'b1;
    end
  end

  // Datapath: grant latch, word stream, event counter and ack timeout
  always_ff @(posedge clk_5 or posedge rst) begin
    if (rst) begin
      r_src         <= '0;
      r_last_grant  <= PTR_RST;
      r_widx        <= '0;
      r_rd_valid    <= 1'b0;
      r_rd_last     <= 1'b0;
      r_rd_data     <= '0;
      r_evt_count   <= '0;
      r_ack_timeout <= 1'b0;
      r_tmo_cnt     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_any) begin
            r_src        <= w_grant_idx;
            r_last_grant <= w_grant_idx;
            r_widx       <= '0;
            r_rd_valid   <= 1'b1;
            r_rd_data    <= w_ld_data;
            r_rd_last    <= (LAST_W == '0);
          end
        end
        ST_SEND: begin
          if (w_xfer) begin
            if (r_widx == LAST_W) begin
              r_widx     <= '0;
              r_rd_valid <= 1'b0;
              r_rd_last  <= 1'b0;
            end else begin
              r_widx    <= r_widx + 1'b1;
              r_rd_data <= w_ld_data;
              r_rd_last <= ((r_widx + 1'b1) == LAST_W);
            end
          end
        end
        ST_ACK: begin
          r_evt_count <= r_evt_count + 32'd1;
          r_tmo_cnt   <= TMO_W'(WAIT_CLR_TIMEOUT - 1);
        end
        ST_WAIT_CLR: begin
          if (w_src_notify) begin
            if (r_tmo_cnt == '0) r_ack_timeout <= 1'b1;
            else                 r_tmo_cnt     <= r_tmo_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ack_evt     = w_ack_evt;
  assign rd_valid    = r_rd_valid;
  assign rd_data     = r_rd_data;
  assign rd_src      = r_src;
  assign rd_last     = r_rd_last;
  assign evt_count   = r_evt_count;
  assign ack_timeout = r_ack_timeout;

endmodule

// File: tb/tb_tagger_readout_arbiter.sv
// Directed bench for tagger_readout_arbiter: a vector table for the basic
// single-event record plus hand sequences for arbitration, backpressure,
// stuck notify, counter wrap and reset in mid-record.
module tb_tagger_readout_arbiter;

  localparam int NB = 4;
  localparam int NW = 6;

  logic                  clk_5 = 1'b0;
  logic                  rst;
  logic [NB-1:0]         notify_evt;
  logic [NB*NW*32-1:0]   blk_data;
  logic [NB-1:0]         ack_evt;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [31:0]           rd_data;
  logic [2:0]            rd_src;
  logic                  rd_last;
  logic [31:0]           evt_count;
  logic                  ack_timeout;

  int n_cmp = 0;
  int n_bad = 0;
  int wexp  = 0;

  typedef struct {
    logic [3:0]  notify;
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_last;
    logic [3:0]  exp_ack;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t tbl [9];

  always #5 clk_5 = ~clk_5;

  tagger_readout_arbiter #(.N_BLK(NB), .N_WORDS(NW)) dut (
    .clk_5       (clk_5),
    .rst         (rst),
    .notify_evt  (notify_evt),
    .blk_data    (blk_data),
    .ack_evt     (ack_evt),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .rd_src      (rd_src),
    .rd_last     (rd_last),
    .evt_count   (evt_count),
    .ack_timeout (ack_timeout)
  );

  function automatic logic [31:0] wd(input int b, input int w);
    return 32'(b * 256 + 16 + w);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: track the expected word index, then sample 1 ns after the edge
  task automatic tick();
    if (rd_valid && rd_ready) wexp = (wexp == NW - 1) ? 0 : wexp + 1;
    @(posedge clk_5);
    #1;
    chk("ack_onehot", 32'($onehot0(ack_evt)), 32'd1);
    if (rd_valid) begin
      chk("word_data", rd_data, wd(int'(rd_src), wexp));
      chk("word_last", 32'(rd_last), 32'(wexp == NW - 1));
    end
  endtask

  task automatic wait_ack(input int b, input string name);
    int c = 0;
    while (ack_evt == '0 && c < 80) begin tick(); c++; end
    chk({name, "_ack"}, 32'(ack_evt), 32'(1 << b));
    chk({name, "_src"}, 32'(rd_src), 32'(b));
  endtask

  task automatic wait_ack_drop(input string name);
    int c = 0;
    while (ack_evt != '0 && c < 40) begin tick(); c++; end
    chk({name, "_ackdrop"}, 32'(ack_evt), 32'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    wexp = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] got [4];
    logic [3:0] pend;
    logic [3:0] prev_ack;
    int         n;
    int         c;

    rst        = 1'b1;
    notify_evt = '0;
    rd_ready   = 1'b0;
    for (int b = 0; b < NB; b++)
      for (int w = 0; w < NW; w++)
        blk_data[(b * NW + w) * 32 +: 32] = wd(b, w);

    //            notify   rdy valid data    last ack     cnt
    tbl[0] = '{4'b0001, 1'b1, 1'b1, 32'h10, 1'b0, 4'b0000, 32'd0};
    tbl[1] = '{4'b0001, 1'b1, 1'b1, 32'h11, 1'b0, 4'b0000, 32'd0};
    tbl[2] = '{4'b0001, 1'b1, 1'b1, 32'h12, 1'b0, 4'b0000, 32'd0};
    tbl[3] = '{4'b0001, 1'b1, 1'b1, 32'h13, 1'b0, 4'b0000, 32'd0};
    tbl[4] = '{4'b0001, 1'b1, 1'b1, 32'h14, 1'b0, 4'b0000, 32'd0};
    tbl[5] = '{4'b0001, 1'b1, 1'b1, 32'h15, 1'b1, 4'b0000, 32'd0};
    tbl[6] = '{4'b0001, 1'b1, 1'b0, 32'h0,  1'b0, 4'b0001, 32'd0};
    tbl[7] = '{4'b0001, 1'b1, 1'b0, 32'h0,  1'b0, 4'b0001, 32'd1};
    tbl[8] = '{4'b0000, 1'b1, 1'b0, 32'h0,  1'b0, 4'b0000, 32'd1};

    repeat (3) @(posedge clk_5);
    #1;
    chk("rst_valid",   32'(rd_valid),    32'd0);
    chk("rst_last",    32'(rd_last),     32'd0);
    chk("rst_data",    rd_data,          32'd0);
    chk("rst_src",     32'(rd_src),      32'd0);
    chk("rst_ack",     32'(ack_evt),     32'd0);
    chk("rst_count",   evt_count,        32'd0);
    chk("rst_timeout", 32'(ack_timeout), 32'd0);
    rst = 1'b0;
    tick();

    // single event, table driven
    for (int i = 0; i < 9; i++) begin
      notify_evt = tbl[i].notify;
      rd_ready   = tbl[i].ready;
      tick();
      chk($sformatf("tbl%0d_valid", i), 32'(rd_valid), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) begin
        chk($sformatf("tbl%0d_data", i), rd_data, tbl[i].exp_data);
        chk($sformatf("tbl%0d_last", i), 32'(rd_last), 32'(tbl[i].exp_last));
      end
      chk($sformatf("tbl%0d_src", i), 32'(rd_src), 32'd0);
      chk($sformatf("tbl%0d_ack", i), 32'(ack_evt), 32'(tbl[i].exp_ack));
      chk($sformatf("tbl%0d_cnt", i), evt_count, tbl[i].exp_cnt);
    end

    // round robin from a fresh pointer: 0, 1, 3 then 0 again
    pulse_reset();
    chk("rr_rst_count", evt_count, 32'd0);
    notify_evt = 4'b1011;
    rd_ready   = 1'b1;
    pend = '0; prev_ack = '0; n = 0; c = 0;
    for (int k = 0; k < 4; k++) got[k] = '0;
    while (!(n == 3 && ack_evt == '0) && c < 300) begin
      tick();
      c++;
      if (pend != '0) begin notify_evt = notify_evt & ~pend; pend = '0; end
      if (ack_evt != '0 && prev_ack == '0) begin
        if (n < 4) got[n] = ack_evt;
        n++;
        pend = ack_evt;
      end
      prev_ack = ack_evt;
    end
    chk("rr_n",    32'(n),      32'd3);
    chk("rr_1st",  32'(got[0]), 32'b0001);
    chk("rr_2nd",  32'(got[1]), 32'b0010);
    chk("rr_3rd",  32'(got[2]), 32'b1000);
    notify_evt = 4'b0001;
    wait_ack(0, "rr_again");
    notify_evt = '0;
    wait_ack_drop("rr_again");
    chk("rr_count", evt_count, 32'd4);

    // backpressure after word 2, with notify dropped mid-record
    notify_evt = 4'b0010;
    rd_ready   = 1'b1;
    repeat (3) tick();
    chk("bp_word2", rd_data, wd(1, 2));
    rd_ready   = 1'b0;
    notify_evt = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("bp_hold%0d_valid", k), 32'(rd_valid), 32'd1);
      chk($sformatf("bp_hold%0d_data", k), rd_data, wd(1, 2));
    end
    rd_ready = 1'b1;
    wait_ack(1, "bp");
    wait_ack_drop("bp");
    chk("bp_count", evt_count, 32'd5);

    // stuck notify on block 2
    notify_evt = 4'b0100;
    wait_ack(2, "stuck");
    repeat (16) tick();
    chk("stuck_ack16",  32'(ack_evt),     32'b0100);
    chk("stuck_tmo16",  32'(ack_timeout), 32'd0);
    tick();
    chk("stuck_ack_off", 32'(ack_evt),     32'd0);
    chk("stuck_tmo",     32'(ack_timeout), 32'd1);
    chk("stuck_idle",    32'(rd_valid),    32'd0);
    tick();
    chk("stuck_regrant_valid", 32'(rd_valid), 32'd1);
    chk("stuck_regrant_src",   32'(rd_src),   32'd2);
    notify_evt = '0;
    wait_ack(2, "stuck_re");
    wait_ack_drop("stuck_re");
    chk("stuck_tmo_sticky", 32'(ack_timeout), 32'd1);
    chk("stuck_count",      evt_count,        32'd7);

    // event counter wrap
    force dut.r_evt_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_evt_count;
    chk("wrap_preset", evt_count, 32'hFFFF_FFFF);
    notify_evt = 4'b0001;
    wait_ack(0, "wrap");
    notify_evt = '0;
    wait_ack_drop("wrap");
    chk("wrap_count", evt_count, 32'd0);

    // reset while word 3 of block 3 is presented
    notify_evt = 4'b1000;
    rd_ready   = 1'b1;
    repeat (4) tick();
    chk("mid_word3", rd_data, wd(3, 3));
    rst = 1'b1;
    #2;
    chk("mid_rst_valid",   32'(rd_valid),    32'd0);
    chk("mid_rst_last",    32'(rd_last),     32'd0);
    chk("mid_rst_data",    rd_data,          32'd0);
    chk("mid_rst_src",     32'(rd_src),      32'd0);
    chk("mid_rst_ack",     32'(ack_evt),     32'd0);
    chk("mid_rst_count",   evt_count,        32'd0);
    chk("mid_rst_timeout", 32'(ack_timeout), 32'd0);
    rst  = 1'b0;
    wexp = 0;
    tick();
    chk("mid_fresh_first", rd_data, wd(3, 0));
    wait_ack(3, "mid_rec");
    chk("mid_cnt_at_ack", evt_count, 32'd0);
    notify_evt = '0;
    wait_ack_drop("mid_rec");
    chk("mid_count", evt_count, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tagger_readout_arbiter.md
TAGGER_READOUT_ARBITER -- requirements
Module: tagger_readout_arbiter

Interface
REQ-001 SHALL have parameter N_BLK, default 4, meaning number of tagger blocks served (2..8).
REQ-002 SHALL have parameter N_WORDS, default 6, meaning 32-bit words per event record.
REQ-003 SHALL have port clk_5  in  1  clock for all logic; one clock; posedge only.
REQ-004 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port notify_evt  in  N_BLK  per-block event-pending flag (level).
REQ-006 SHALL have port blk_data  in  N_BLK*N_WORDS*32  flattened event words; block b, word w at bits [(b*N_WORDS+w)*32 +: 32].
REQ-007 SHALL have port ack_evt  out  N_BLK  per-block acknowledge (level).
REQ-008 SHALL have port rd_valid  out  1  HPS-side word valid.
REQ-009 SHALL have port rd_ready  in  1  HPS-side word accepted.
REQ-010 SHALL have port rd_data  out  32  current word.
REQ-011 SHALL have port rd_src  out  3  index of the block being read.
REQ-012 SHALL have port rd_last  out  1  high with the final word of a record.
REQ-013 SHALL have port evt_count  out  32  records fully delivered since reset.
REQ-014 SHALL have port ack_timeout  out  1  sticky flag: a block failed to drop notify.

Function
REQ-015 SHALL implement FSM states IDLE, SEND, ACK, WAIT_CLR.
REQ-016 IDLE: if any notify_evt bit is set, grant the first set bit searching upward (with wrap) from last_grant+1; latch index into src; go to SEND next cycle.
REQ-017 Round-robin pointer last_grant SHALL update only on grant; reset value N_BLK-1, so block 0 has first priority.
REQ-018 SEND: rd_valid=1, rd_data=blk_data word[src][widx], rd_src=src, rd_last=(widx==N_WORDS-1).
REQ-019 Each rd_valid&rd_ready cycle SHALL advance widx; on the last word transfer go to ACK, widx back to 0.
REQ-020 rd_valid SHALL be registered and SHALL NOT drop while rd_ready is low (no word retraction).
REQ-021 First word SHALL be presented one cycle after the grant; with rd_ready held high a record takes N_WORDS cycles.
REQ-022 ACK: drive ack_evt[src]=1, all other ack bits 0; increment evt_count (wraps 0xFFFFFFFF->0); go to WAIT_CLR.
REQ-023 WAIT_CLR: hold ack_evt[src]=1 until notify_evt[src]==0, then drop ack the next cycle and return to IDLE.
REQ-024 WAIT_CLR SHALL time out after 16 cycles: set ack_timeout, drop ack, return to IDLE.
REQ-025 A notify_evt bit rising while another block is served SHALL wait; it is not lost, since the level persists.
REQ-026 notify_evt[src] dropping during SEND SHALL NOT abort the record; the record SHALL complete from the current blk_data.
REQ-027 At most one ack_evt bit SHALL be high at any time.

Reset
REQ-028 On rst: state IDLE, rd_valid=0, rd_last=0, rd_data=0, rd_src=0, ack_evt=0, widx=0, evt_count=0, ack_timeout=0, last_grant=N_BLK-1.
REQ-029 rst asserted mid-record SHALL discard the record without ack; the pending block re-notifies and is served again after reset.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding, the WAIT_CLR timeout constant (16) and the default N_WORDS.
REQ-031 The round-robin grant search SHALL be a sub-module rr_grant (request vector plus pointer in, one-hot grant plus index out, purely combinational).
REQ-032 The block SHALL sit between N_BLK tagger blocks and the HPS bridge, replacing direct per-block notify/ack wiring.

Verification
REQ-033 Single event: notify_evt=4'b0001, blk0 words 0x10..0x15, rd_ready=1 -> 6 words 0x10..0x15 on consecutive cycles, rd_last on 0x15, ack_evt=0001 until notify drops, evt_count=1.
REQ-034 Round-robin: notify_evt=4'b1011 held, each notify clearing one cycle after its ack -> service order 0,1,3, then 0 again on a new notify.
REQ-035 Backpressure: rd_ready low for 3 cycles after word 2 -> rd_valid stays 1, rd_data stays word 2, no skipped or duplicated word.
REQ-036 Stuck notify: notify_evt[2] held high after ack -> ack_timeout=1 after 16 WAIT_CLR cycles, FSM in IDLE, block 2 regranted.
REQ-037 Reset mid-SEND: rst pulse at word 3 -> all outputs return to reset values, evt_count=0, and a fresh full record is delivered after reset.
REQ-038 Counter wrap: evt_count forced to 0xFFFFFFFF, one record delivered -> evt_count=0.
